descrambler: RTL and testbench

DESCRAMBLER -- requirements
Module: descrambler

---
 rtl/descrambler_if.sv | 33 +++
 rtl/descrambler.sv | 163 ++++++++++++++++
 tb/tb_descrambler.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/descrambler_if.sv
// Serial descrambler bus: frame start, the input bit stream with its
// valid/ready/last handshake, the output bit stream with its own handshake,
// and the recovered-seed / error status reported back to the controller.
//   master : the side that feeds scrambled bits and consumes descrambled bits
//   slave  : the descrambler itself
interface descrambler_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;
  logic [6:0] seed_out;
  logic       seed_valid;
  logic       seed_err;
  logic       svc_err;
  logic       busy;

  modport master (
    output start, in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_bit, out_last,
    input  seed_out, seed_valid, seed_err, svc_err, busy
  );

  modport slave (
    input  start, in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_bit, out_last,
    output seed_out, seed_valid, seed_err, svc_err, busy
  );
endinterface

// File: rtl/descrambler.sv
// Self-synchronising descrambler for the x^7+x^4+1 frame scrambler.
// The first 7 bits of a frame load the scrambler state directly, the next 9
// SERVICE bits must descramble to zero, and every later bit is descrambled
// and forwarded until in_last. Output goes through a 1-deep register, so
// in_ready drops only while that register is full and not being drained.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : start, in_valid/in_ready/in_bit/in_last,
//                  out_valid/out_ready/out_bit/out_last,
//                  seed_out, seed_valid, seed_err, svc_err, busy
// Parameter STRIP_SERVICE: 1 drops the 16 SERVICE bits from the output,
//   0 forwards them (the 7 seed bits appear as zeros).
module descrambler #(
  parameter int STRIP_SERVICE = 1
) (
  input  logic         clk,
  input  logic         reset,
  descrambler_if.slave bus
);
  localparam bit Strip = (STRIP_SERVICE != 0);

  typedef enum logic [1:0] {IDLE, SEED, SVC, DATA} state_t;

  state_t     state, next_state;
  logic [6:0] s;
  logic [3:0] cnt;
  logic       out_valid_q, out_bit_q, out_last_q;
  logic [6:0] seed_q;
  logic       seed_valid_q, seed_err_q, svc_err_q;

  logic       in_ready_c, accept, fb, desc_bit;
  logic       emit, emit_bit, emit_last;
  logic [6:0] seed_next;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic. start restarts the frame even mid-frame; in_last in
  // the SERVICE field ends a frame that is too short.
  always_comb begin
    next_state = state;
    if (bus.start) begin
      next_state = SEED;
    end else if (accept) begin
      case (state)
        SEED: begin
          if (bus.in_last)       next_state = IDLE;
          else if (cnt == 4'd6)  next_state = SVC;
        end
        SVC: begin
          if (bus.in_last)       next_state = IDLE;
          else if (cnt == 4'd15) next_state = DATA;
        end
        DATA: begin
          if (bus.in_last)       next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Handshake and per-bit decode. A bit offered together with start is
  // dropped, so accept is masked by start.
  always_comb begin
    in_ready_c = (state != IDLE) && (!out_valid_q || bus.out_ready);
    accept     = bus.in_valid && in_ready_c && !bus.start;
    fb         = s[6] ^ s[3];
    desc_bit   = bus.in_bit ^ fb;
    seed_next  = {s[5:0], bus.in_bit};
    emit       = 1'b0;
    emit_bit   = 1'b0;
    emit_last  = 1'b0;
    if (accept) begin
      case (state)
        SEED: begin
          emit      = !Strip;
          emit_last = bus.in_last;
        end
        SVC: begin
          emit      = !Strip;
          emit_bit  = desc_bit;
          emit_last = bus.in_last;
        end
        DATA: begin
          emit      = 1'b1;
          emit_bit  = desc_bit;
          emit_last = bus.in_last;
        end
        default: ;
      endcase
    end
  end

  // Scrambler state, SERVICE counter, output register and frame flags.
  // The recovered seed is the state after the 7th bit; an all-zero seed is
  // flagged but the frame still runs (bits then pass through unchanged).
  always_ff @(posedge clk) begin
    if (reset) begin
      s            <= '0;
      cnt          <= '0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_last_q   <= 1'b0;
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
      seed_err_q   <= 1'b0;
      svc_err_q    <= 1'b0;
    end else if (bus.start) begin
      cnt          <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      seed_valid_q <= 1'b0;
      seed_err_q   <= 1'b0;
      svc_err_q    <= 1'b0;
    end else begin
      if (emit) begin
        out_valid_q <= 1'b1;
        out_bit_q   <= emit_bit;
        out_last_q  <= emit_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        case (state)
          SEED: begin
            s   <= seed_next;
            cnt <= cnt + 4'd1;
            if (bus.in_last) begin
              svc_err_q <= 1'b1;
            end else if (cnt == 4'd6) begin
              seed_q       <= seed_next;
              seed_valid_q <= 1'b1;
              seed_err_q   <= (seed_next == 7'd0);
            end
          end
          SVC: begin
            s   <= {s[5:0], fb};
            cnt <= cnt + 4'd1;
            if (desc_bit || bus.in_last) svc_err_q <= 1'b1;
          end
          DATA: begin
            s <= {s[5:0], fb};
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_bit    = out_bit_q;
  assign bus.out_last   = out_last_q;
  assign bus.seed_out   = seed_q;
  assign bus.seed_valid = seed_valid_q;
  assign bus.seed_err   = seed_err_q;
  assign bus.svc_err    = svc_err_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_descrambler.sv
// Bench for descrambler: one instance strips the SERVICE field, one forwards
// it. Both share the input stream; frames are built by a reference scrambler
// and the descrambled output is compared with the original plaintext.
module tb_descrambler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic start, in_valid, in_bit, in_last;
  logic bp_en;
  logic bp_rnd = 1'b1;

  descrambler_if bus_s();
  descrambler_if bus_k();

  assign bus_s.start     = start;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_bit    = in_bit;
  assign bus_s.in_last   = in_last;
  assign bus_s.out_ready = bp_en ? bp_rnd : 1'b1;
  assign bus_k.start     = start;
  assign bus_k.in_valid  = in_valid;
  assign bus_k.in_bit    = in_bit;
  assign bus_k.in_last   = in_last;
  assign bus_k.out_ready = 1'b1;

  descrambler #(.STRIP_SERVICE(1)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));
  descrambler #(.STRIP_SERVICE(0)) dut_k (.clk(clk), .reset(reset), .bus(bus_k));

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int k_first_acc = -1;
  int k_first_out = -1;
  int ready_viol = 0;

  logic rx_s[$];
  logic rxl_s[$];
  logic rx_k[$];
  logic rxl_k[$];
  logic pay[$];
  logic plain[$];
  logic tx[$];
  logic [6:0] exp_seed;

  // Downstream readiness toggles just after each rising edge when enabled.
  always @(posedge clk) begin
    #1;
    bp_rnd = 1'($urandom_range(0, 1));
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: records transfers that the next rising edge performs.
  always @(negedge clk) begin
    if (bus_s.out_valid && bus_s.out_ready) begin
      rx_s.push_back(bus_s.out_bit);
      rxl_s.push_back(bus_s.out_last);
    end
    if (bus_k.out_valid && bus_k.out_ready) begin
      rx_k.push_back(bus_k.out_bit);
      rxl_k.push_back(bus_k.out_last);
    end
    if (bus_k.in_valid && bus_k.in_ready && !start && k_first_acc < 0) k_first_acc = cyc;
    if (bus_k.out_valid && k_first_out < 0) k_first_out = cyc;
    if (bus_s.busy && (bus_s.in_ready !== (!bus_s.out_valid || bus_s.out_ready))) ready_viol++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [14:0] status_s();
    return {bus_s.in_ready, bus_s.out_valid, bus_s.out_bit, bus_s.out_last, bus_s.seed_out,
            bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err, bus_s.busy};
  endfunction

  function automatic logic [14:0] status_k();
    return {bus_k.in_ready, bus_k.out_valid, bus_k.out_bit, bus_k.out_last, bus_k.seed_out,
            bus_k.seed_valid, bus_k.seed_err, bus_k.svc_err, bus_k.busy};
  endfunction

  // Reference scrambler: 16 SERVICE bits (optionally one reserved bit set)
  // followed by pay[], scrambled from the given initial state.
  task automatic build_frame(input logic [6:0] seed, input int flip);
    logic [6:0] st;
    logic f;
    plain.delete();
    tx.delete();
    for (int i = 0; i < 16; i++) plain.push_back(i == flip);
    foreach (pay[i]) plain.push_back(pay[i]);
    st = seed;
    foreach (plain[i]) begin
      f = st[6] ^ st[3];
      tx.push_back(plain[i] ^ f);
      st = {st[5:0], f};
      if (i == 6) exp_seed = st;
    end
  endtask

  task automatic set_pay(input logic [31:0] v, input int n);
    pay.delete();
    for (int i = n - 1; i >= 0; i--) pay.push_back(v[i]);
  endtask

  task automatic clear_rx();
    rx_s.delete(); rxl_s.delete(); rx_k.delete(); rxl_k.delete();
    k_first_acc = -1;
    k_first_out = -1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  // Offers one bit and holds it until the stripping instance accepts it.
  task automatic send_bit(input logic b, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    @(negedge clk);
    while (bus_s.in_ready !== 1'b1) begin
      waited++;
      if (waited > 64) begin
        compared++; mismatched++;
        $display("[TB] FAIL send_timeout: in_ready low for %0d cycles, required 1", waited);
        break;
      end
      @(negedge clk);
    end
    next_cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    compared++;
    if (status_s() !== 15'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_strip: status %b, required all zero", status_s());
    end
    compared++;
    if (status_k() !== 15'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_keep: status %b, required all zero", status_k());
    end
    reset = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    repeat (3) next_cycle();
    compared++;
    if ({bus_s.busy, bus_s.in_ready, bus_s.out_valid, bus_k.out_valid} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL idle_ignore: busy/in_ready/out_valid_s/out_valid_k %b, required 0000",
               {bus_s.busy, bus_s.in_ready, bus_s.out_valid, bus_k.out_valid});
    end
    in_valid = 1'b0;
    in_bit = 1'b0;
  endtask

  task automatic test_zero_frame();
    pay.delete();
    for (int i = 0; i < 24; i++) pay.push_back(1'b0);
    build_frame(7'b1111111, -1);
    clear_rx();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      send_bit(tx[i], i == 39);
      if (i == 5) begin
        compared++;
        if (bus_s.seed_valid !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL seed_valid_early: got %b after 6 bits, required 0", bus_s.seed_valid);
        end
      end
      if (i == 6) begin
        compared++;
        if (bus_s.seed_valid !== 1'b1 || bus_s.seed_out !== 7'b0000111) begin
          mismatched++;
          $display("[TB] FAIL seed_after_7: valid %b seed %b, required 1 0000111",
                   bus_s.seed_valid, bus_s.seed_out);
        end
      end
    end
    repeat (3) next_cycle();
    compared++;
    if ({bus_s.seed_out, bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err, bus_s.busy} !== 11'b0000111_1_0_0_0) begin
      mismatched++;
      $display("[TB] FAIL zero_frame_flags: seed/valid/serr/verr/busy %b_%b%b%b%b, required 0000111_1000",
               bus_s.seed_out, bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err, bus_s.busy);
    end
    compared++;
    if (rx_s.size() !== 24) begin
      mismatched++;
      $display("[TB] FAIL zero_frame_strip_count: got %0d outputs, required 24", rx_s.size());
    end
    for (int i = 0; i < 24; i++) begin
      compared++;
      if (i >= rx_s.size() || rx_s[i] !== 1'b0 || rxl_s[i] !== (i == 23)) begin
        mismatched++;
        $display("[TB] FAIL zero_frame_strip_bit%0d: got bit/last %b/%b, required 0/%b", i,
                 i >= rx_s.size() ? 1'bx : rx_s[i], i >= rx_s.size() ? 1'bx : rxl_s[i], i == 23);
      end
    end
    compared++;
    if (rx_k.size() !== 40) begin
      mismatched++;
      $display("[TB] FAIL zero_frame_keep_count: got %0d outputs, required 40", rx_k.size());
    end
    for (int i = 0; i < 40; i++) begin
      compared++;
      if (i >= rx_k.size() || rx_k[i] !== 1'b0 || rxl_k[i] !== (i == 39)) begin
        mismatched++;
        $display("[TB] FAIL zero_frame_keep_bit%0d: got bit/last %b/%b, required 0/%b", i,
                 i >= rx_k.size() ? 1'bx : rx_k[i], i >= rx_k.size() ? 1'bx : rxl_k[i], i == 39);
      end
    end
    compared++;
    if (k_first_out - k_first_acc !== 1) begin
      mismatched++;
      $display("[TB] FAIL keep_latency: first output %0d cycles after first accept, required 1",
               k_first_out - k_first_acc);
    end
  endtask

  task automatic test_seed_zero();
    set_pay(32'hB2, 8);
    build_frame(7'b0000000, -1);
    clear_rx();
    pulse_start();
    for (int i = 0; i < 24; i++) send_bit(tx[i], i == 23);
    repeat (3) next_cycle();
    compared++;
    if ({bus_s.seed_out, bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err} !== 10'b0000000_1_1_0) begin
      mismatched++;
      $display("[TB] FAIL seed_zero_flags: seed/valid/serr/verr %b_%b%b%b, required 0000000_110",
               bus_s.seed_out, bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err);
    end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (i >= rx_s.size() || rx_s[i] !== tx[16 + i] || rx_s[i] !== pay[i]) begin
        mismatched++;
        $display("[TB] FAIL seed_zero_passthru_bit%0d: got %b, required %b", i,
                 i >= rx_s.size() ? 1'bx : rx_s[i], pay[i]);
      end
    end
    compared++;
    if (bus_k.seed_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL seed_zero_keep_err: got %b, required 1", bus_k.seed_err);
    end
  endtask

  task automatic test_svc_flag();
    set_pay(32'hC5, 8);
    build_frame(7'h35, 11);
    clear_rx();
    pulse_start();
    for (int i = 0; i < 24; i++) send_bit(tx[i], i == 23);
    repeat (3) next_cycle();
    compared++;
    if ({bus_s.seed_out, bus_s.seed_err, bus_s.svc_err} !== {exp_seed, 2'b01}) begin
      mismatched++;
      $display("[TB] FAIL svc_flag_flags: seed/serr/verr %b_%b%b, required %b_01",
               bus_s.seed_out, bus_s.seed_err, bus_s.svc_err, exp_seed);
    end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (i >= rx_s.size() || rx_s[i] !== pay[i]) begin
        mismatched++;
        $display("[TB] FAIL svc_flag_payload_bit%0d: got %b, required %b", i,
                 i >= rx_s.size() ? 1'bx : rx_s[i], pay[i]);
      end
    end
    compared++;
    if (rx_k.size() !== 24) begin
      mismatched++;
      $display("[TB] FAIL svc_flag_keep_count: got %0d outputs, required 24", rx_k.size());
    end
    for (int i = 0; i < 24; i++) begin
      compared++;
      if (i >= rx_k.size() || rx_k[i] !== plain[i]) begin
        mismatched++;
        $display("[TB] FAIL svc_flag_keep_bit%0d: got %b, required %b", i,
                 i >= rx_k.size() ? 1'bx : rx_k[i], plain[i]);
      end
    end
  endtask

  task automatic test_short_frame();
    pay.delete();
    build_frame(7'b1111111, -1);
    clear_rx();
    pulse_start();
    for (int i = 0; i < 10; i++) send_bit(tx[i], i == 9);
    compared++;
    if ({bus_s.busy, bus_k.busy, bus_s.svc_err, bus_k.svc_err, bus_s.seed_valid} !== 5'b00111) begin
      mismatched++;
      $display("[TB] FAIL short_frame_state: busy_s/busy_k/verr_s/verr_k/seedv %b, required 00111",
               {bus_s.busy, bus_k.busy, bus_s.svc_err, bus_k.svc_err, bus_s.seed_valid});
    end
    repeat (2) next_cycle();
    compared++;
    if (rx_s.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL short_frame_strip_out: got %0d outputs, required 0", rx_s.size());
    end
    compared++;
    if (rx_k.size() !== 10) begin
      mismatched++;
      $display("[TB] FAIL short_frame_keep_count: got %0d outputs, required 10", rx_k.size());
    end
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (i >= rx_k.size() || rx_k[i] !== 1'b0 || rxl_k[i] !== (i == 9)) begin
        mismatched++;
        $display("[TB] FAIL short_frame_keep_bit%0d: got bit/last %b/%b, required 0/%b", i,
                 i >= rx_k.size() ? 1'bx : rx_k[i], i >= rx_k.size() ? 1'bx : rxl_k[i], i == 9);
      end
    end
  endtask

  task automatic test_backpressure();
    pay.delete();
    for (int i = 0; i < 32; i++) pay.push_back(1'($urandom_range(0, 1)));
    build_frame(7'h5A, -1);
    clear_rx();
    ready_viol = 0;
    pulse_start();
    bp_en = 1'b1;
    for (int i = 0; i < 48; i++) send_bit(tx[i], i == 47);
    for (int w = 0; w < 64 && rx_s.size() < 32; w++) next_cycle();
    bp_en = 1'b0;
    compared++;
    if (rx_s.size() !== 32) begin
      mismatched++;
      $display("[TB] FAIL backpressure_count: got %0d outputs, required 32", rx_s.size());
    end
    for (int i = 0; i < 32; i++) begin
      compared++;
      if (i >= rx_s.size() || rx_s[i] !== pay[i] || rxl_s[i] !== (i == 31)) begin
        mismatched++;
        $display("[TB] FAIL backpressure_bit%0d: got bit/last %b/%b, required %b/%b", i,
                 i >= rx_s.size() ? 1'bx : rx_s[i], i >= rx_s.size() ? 1'bx : rxl_s[i], pay[i], i == 31);
      end
    end
    compared++;
    if (ready_viol !== 0) begin
      mismatched++;
      $display("[TB] FAIL backpressure_in_ready: %0d cycles violated handshake, required 0", ready_viol);
    end
  endtask

  task automatic test_abort();
    set_pay(32'hA3, 8);
    build_frame(7'b0000000, 9);
    pulse_start();
    for (int i = 0; i < 20; i++) send_bit(tx[i], 1'b0);
    compared++;
    if ({bus_s.seed_err, bus_s.svc_err, bus_s.seed_valid} !== 3'b111) begin
      mismatched++;
      $display("[TB] FAIL abort_pre_flags: serr/verr/seedv %b, required 111",
               {bus_s.seed_err, bus_s.svc_err, bus_s.seed_valid});
    end
    start = 1'b1;
    in_valid = 1'b1;
    in_bit = tx[20];
    next_cycle();
    start = 1'b0;
    in_valid = 1'b0;
    compared++;
    if ({bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err, bus_s.out_valid, bus_s.busy} !== 5'b00001) begin
      mismatched++;
      $display("[TB] FAIL abort_cleared: seedv/serr/verr/outv/busy %b, required 00001",
               {bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err, bus_s.out_valid, bus_s.busy});
    end
    clear_rx();
    set_pay(32'hCA7, 12);
    build_frame(7'h2B, -1);
    for (int i = 0; i < 28; i++) send_bit(tx[i], i == 27);
    repeat (3) next_cycle();
    compared++;
    if ({bus_s.seed_out, bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err} !== {exp_seed, 3'b100}) begin
      mismatched++;
      $display("[TB] FAIL abort_new_seed: seed/valid/serr/verr %b_%b%b%b, required %b_100",
               bus_s.seed_out, bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err, exp_seed);
    end
    for (int i = 0; i < 12; i++) begin
      compared++;
      if (i >= rx_s.size() || rx_s[i] !== pay[i]) begin
        mismatched++;
        $display("[TB] FAIL abort_new_payload_bit%0d: got %b, required %b", i,
                 i >= rx_s.size() ? 1'bx : rx_s[i], pay[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_pay(32'h9, 4);
    build_frame(7'h11, 8);
    pulse_start();
    for (int i = 0; i < 11; i++) send_bit(tx[i], 1'b0);
    reset = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    in_bit = tx[11];
    next_cycle();
    compared++;
    if (status_s() !== 15'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_strip: status %b, required all zero", status_s());
    end
    compared++;
    if (status_k() !== 15'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_keep: status %b, required all zero", status_k());
    end
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    clear_rx();
    set_pay(32'h1A, 6);
    build_frame(7'h66, -1);
    pulse_start();
    for (int i = 0; i < 22; i++) send_bit(tx[i], i == 21);
    repeat (3) next_cycle();
    compared++;
    if ({bus_s.seed_out, bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err} !== {exp_seed, 3'b100}) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_new_seed: seed/valid/serr/verr %b_%b%b%b, required %b_100",
               bus_s.seed_out, bus_s.seed_valid, bus_s.seed_err, bus_s.svc_err, exp_seed);
    end
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (i >= rx_s.size() || rx_s[i] !== pay[i]) begin
        mismatched++;
        $display("[TB] FAIL reset_mid_payload_bit%0d: got %b, required %b", i,
                 i >= rx_s.size() ? 1'bx : rx_s[i], pay[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    in_last = 1'b0;
    bp_en = 1'b0;
    test_reset();
    test_zero_frame();
    test_seed_zero();
    test_svc_flag();
    test_short_frame();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
